// File: rtl/alu_result_collector.sv
// Collects single-unit ALU results into a first-word-fall-through FIFO with sticky error flags.
// Optional drop counter enabled by defining ALU_COLLECT_DROP_CNT_EN.
module alu_result_collector #(
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OUT_WIDTH-1:0]     ARITHMETIC_OUT,
  input  logic [OUT_WIDTH-1:0]     Logic_OUT,
  input  logic [OUT_WIDTH-1:0]     CMP_OUT,
  input  logic [OUT_WIDTH-1:0]     SHIFT_OUT,
  input  logic                     ARITHMETIC_Flag,
  input  logic                     Logic_Flag,
  input  logic                     CMP_Flag,
  input  logic                     SHIFT_Flag,
  input  logic                     Carry_OUT,
  input  logic                     res_ready,
  input  logic                     err_clr,
  output logic                     res_valid,
  output logic [OUT_WIDTH-1:0]     res_data,
  output logic [1:0]               res_unit,
  output logic                     res_carry,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow_err,
  output logic                     collision_err
`ifdef ALU_COLLECT_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    UnitArith = 2'b00,
    UnitLogic = 2'b01,
    UnitCmp   = 2'b10,
    UnitShift = 2'b11
  } unit_e;

  // Flag decode
  logic [3:0]           flag_vec;
  logic [2:0]           flag_cnt;
  logic                 capture;
  logic                 collision;
  logic [OUT_WIDTH-1:0] cap_data;
  unit_e                cap_unit;
  logic                 cap_carry;

  assign flag_vec = {SHIFT_Flag, CMP_Flag, Logic_Flag, ARITHMETIC_Flag};

  always_comb begin
    flag_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      flag_cnt = flag_cnt + {2'b00, flag_vec[i]};
    end
  end

  assign capture   = (flag_cnt == 3'd1);
  assign collision = (flag_cnt > 3'd1);

  always_comb begin
    cap_data  = '0;
    cap_unit  = UnitArith;
    cap_carry = 1'b0;
    unique case (flag_vec)
      4'b0001: begin
        cap_data  = ARITHMETIC_OUT;
        cap_unit  = UnitArith;
        cap_carry = Carry_OUT;
      end
      4'b0010: begin
        cap_data = Logic_OUT;
        cap_unit = UnitLogic;
      end
      4'b0100: begin
        cap_data = CMP_OUT;
        cap_unit = UnitCmp;
      end
      4'b1000: begin
        cap_data = SHIFT_OUT;
        cap_unit = UnitShift;
      end
      default: ;
    endcase
  end

  // FIFO state
  logic [OUT_WIDTH-1:0] mem_data  [DEPTH];
  logic [1:0]           mem_unit  [DEPTH];
  logic                 mem_carry [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          overflow_evt;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && res_ready;
  // A full FIFO still accepts when the head leaves on the same edge
  assign push         = capture && (!full || pop);
  assign overflow_evt = capture && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only occupied slots are ever presented
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_data[wr_ptr_q]  <= cap_data;
      mem_unit[wr_ptr_q]  <= cap_unit;
      mem_carry[wr_ptr_q] <= cap_carry;
    end
  end

  // Head presentation
  always_comb begin
    res_valid = !empty;
    res_data  = '0;
    res_unit  = 2'b00;
    res_carry = 1'b0;
    if (!empty) begin
      res_data  = mem_data[rd_ptr_q];
      res_unit  = mem_unit[rd_ptr_q];
      res_carry = mem_carry[rd_ptr_q];
    end
  end

  assign fifo_count = count_q;

  // Sticky errors: a new event outranks a same-cycle clear
  logic ovf_q, ovf_d;
  logic col_q, col_d;

  always_comb begin
    ovf_d = ovf_q;
    col_d = col_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      col_d = 1'b0;
    end
    if (overflow_evt) begin
      ovf_d = 1'b1;
    end
    if (collision) begin
      col_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      col_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      col_q <= col_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign collision_err = col_q;

`ifdef ALU_COLLECT_DROP_CNT_EN
  logic        reject;
  logic [15:0] drop_q, drop_d;

  assign reject = overflow_evt || collision;

  always_comb begin
    drop_d = drop_q;
    if (err_clr) begin
      drop_d = reject ? 16'd1 : 16'd0;
    end else if (reject && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter OUT_WIDTH, default 32, SHALL set the ALU result width; it matches the ALU top-level output width (A width + B width).
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO entry count; legal values are powers of two, >= 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 ARITHMETIC_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  input  OUT_WIDTH each  SHALL be the ALU unit results.
REQ-006 ARITHMETIC_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  input  1 each  SHALL be the ALU result-valid flags, one per unit.
REQ-007 Carry_OUT  input  1  SHALL be the arithmetic carry.
REQ-008 res_valid  output  1  SHALL indicate that the FIFO head is presented.
REQ-009 res_ready  input  1  SHALL be the consumer acceptance; a pop occurs on a clock edge where res_valid=1 and res_ready=1.
REQ-010 res_data  output  OUT_WIDTH  SHALL be the head result.
REQ-011 res_unit  output  2  SHALL be the head source code: 00 arith, 01 logic, 10 cmp, 11 shift.
REQ-012 res_carry  output  1  SHALL be the head carry.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  SHALL be the occupancy.
REQ-014 err_clr  input  1  SHALL be a synchronous clear pulse for the sticky errors.
REQ-015 overflow_err, collision_err  output  1 each  SHALL be sticky error flags.

Function
REQ-016 A capture cycle is any cycle with exactly one flag high; it SHALL push {selected result, unit code, carry} at that edge; carry = Carry_OUT for arith, 0 otherwise.
REQ-017 Cycles with no flag high SHALL push nothing.
REQ-018 Cycles with two or more flags high SHALL push nothing and SHALL set collision_err.
REQ-019 A capture while full without a same-cycle pop SHALL be dropped and SHALL set overflow_err; FIFO contents unchanged.
REQ-020 A capture while full with a same-cycle pop SHALL be accepted; count stays DEPTH.
REQ-021 A push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-022 Latency: a pushed entry SHALL appear at res_valid/res_data on the cycle after the push edge; there is no same-cycle bypass, even when the FIFO is empty.
REQ-023 Output SHALL be first-word-fall-through: res_valid = (fifo_count != 0), and res_data/res_unit/res_carry reflect the head entry.
REQ-024 When empty, res_data, res_unit and res_carry SHALL be driven 0.
REQ-025 res_valid, once high, SHALL hold with stable data until popped.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH, and order SHALL be preserved across wrap.
REQ-027 err_clr SHALL clear both sticky errors; an error event in the same cycle as err_clr SHALL win, leaving the flag set.

Reset
REQ-028 When rst=0 at a clock edge, pointers, fifo_count, overflow_err and collision_err SHALL go to 0, res_valid SHALL go to 0, and res_data/res_unit/res_carry SHALL read 0.
REQ-029 Reset mid-operation SHALL discard all entries; captures in the reset cycle SHALL be ignored.
REQ-030 The first capture SHALL be accepted on the first edge with rst=1.

Configuration
REQ-031 With macro ALU_COLLECT_DROP_CNT_EN defined, the block SHALL add output drop_cnt (16 bits) that counts each rejected capture (overflow or collision), saturates at 16'hFFFF, and resets to 0 on reset or err_clr. A rejection in the same cycle as err_clr SHALL leave drop_cnt = 1.
REQ-032 Without the macro, the drop_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 After reset, Logic_Flag=1 with Logic_OUT=32'h0000_00F0 for one cycle -> the next cycle shows res_valid=1, res_data=32'h0000_00F0, res_unit=01, res_carry=0, fifo_count=1.
REQ-034 ARITHMETIC_Flag=1, ARITHMETIC_OUT=32'hFFFF_0001, Carry_OUT=1, with res_ready=1 -> one cycle later res_unit=00 and res_carry=1; the entry pops on the following edge, and fifo_count returns to 0.
REQ-035 With res_ready=0, apply 9 consecutive CMP captures at DEPTH=8 -> fifo_count=8, overflow_err=1, and the 9th value is absent when draining in order (with the macro, drop_cnt=1).
REQ-036 With the FIFO full and res_ready=1, a SHIFT capture -> accepted, fifo_count stays 8, overflow_err stays 0, and the drain order ends with the SHIFT value.
REQ-037 CMP_Flag=1 and SHIFT_Flag=1 in the same cycle -> no push, collision_err=1; a later err_clr pulse -> collision_err=0.
REQ-038 Hold rst=0 for one cycle with 5 entries queued and a capture present -> next cycle fifo_count=0, res_valid=0, res_data=0.
